// File: rtl/grid_vga_renderer.sv
// Renders the 8x8 colour grid onto a 640x480@60Hz VGA port.
// The grid is latched once per frame at the start of vertical blank so game updates never tear.
module grid_vga_renderer #(
    parameter int TICK_DIV   = 4,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CELL       = 60,
    parameter int X_OFFSET   = 80,
    parameter bit GRID_LINES = 1'b1
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic [3:0] reds   [63:0],
    input  logic [3:0] greens [63:0],
    input  logic [3:0] blues  [63:0],
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       o_frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] GRID_X0  = HW'(X_OFFSET);
    localparam logic [HW-1:0] GRID_X1  = HW'(X_OFFSET + 8 * CELL);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] CELL_LAST = CW'(CELL - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          pix_tick;
    logic [HW-1:0] h_cnt, h_next;
    logic [VW-1:0] v_cnt, v_next;
    logic          h_wrap;
    logic [CW-1:0] lx, ly;
    logic [2:0]    col, row;
    logic          snap;
    logic [3:0]    shadow_r [63:0];
    logic [3:0]    shadow_g [63:0];
    logic [3:0]    shadow_b [63:0];
    logic          active, in_grid, on_line;
    logic [5:0]    cell_idx;
    logic [3:0]    r_p0, g_p0, b_p0;
    logic          hs_n_p0, vs_n_p0;

    assign pix_tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (pix_tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_next = h_wrap ? '0 : h_cnt + HW'(1);
        v_next = v_cnt;
        if (h_wrap)
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Cell-local counters track the pixel the h/v counters will hold after this tick.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            lx  <= '0;
            col <= '0;
            ly  <= '0;
            row <= '0;
        end else if (pix_tick) begin
            if (h_next == GRID_X0) begin
                lx  <= '0;
                col <= '0;
            end else if (lx == CELL_LAST) begin
                lx  <= '0;
                col <= col + 3'd1;
            end else begin
                lx <= lx + CW'(1);
            end
            if (h_wrap) begin
                if (v_next == '0) begin
                    ly  <= '0;
                    row <= '0;
                end else if (ly == CELL_LAST) begin
                    ly  <= '0;
                    row <= row + 3'd1;
                end else begin
                    ly <= ly + CW'(1);
                end
            end
        end
    end

    assign snap          = pix_tick && (h_cnt == '0) && (v_cnt == V_VIS);
    assign o_frame_start = snap && !reset;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                shadow_r[i] <= '0;
                shadow_g[i] <= '0;
                shadow_b[i] <= '0;
            end
        end else if (snap) begin
            shadow_r <= reds;
            shadow_g <= greens;
            shadow_b <= blues;
        end
    end

    // Stage p0: colour and sync for the pixel currently addressed by the counters.
    always_comb begin
        active   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        in_grid  = active && (h_cnt >= GRID_X0) && (h_cnt < GRID_X1);
        on_line  = GRID_LINES && ((lx == '0) || (ly == '0));
        cell_idx = {row, col};
        hs_n_p0  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_n_p0  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        r_p0     = 4'h0;
        g_p0     = 4'h0;
        b_p0     = 4'h0;
        if (in_grid) begin
            if (on_line) begin
                r_p0 = 4'h4;
                g_p0 = 4'h4;
                b_p0 = 4'h4;
            end else begin
                r_p0 = shadow_r[cell_idx];
                g_p0 = shadow_g[cell_idx];
                b_p0 = shadow_b[cell_idx];
            end
        end
    end

    // Stage p1: colour and syncs registered together so they reach the pins aligned.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            VGA_R  <= 4'h0;
            VGA_G  <= 4'h0;
            VGA_B  <= 4'h0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
        end else if (pix_tick) begin
            VGA_R  <= r_p0;
            VGA_G  <= g_p0;
            VGA_B  <= b_p0;
            VGA_HS <= hs_n_p0;
            VGA_VS <= vs_n_p0;
        end
    end
endmodule

// File: tb/tb_grid_vga_renderer.sv
// Bench for grid_vga_renderer on a shrunken raster, with and without grid lines,
// compared against a pixel-index reference model.
module tb_grid_vga_renderer;
    localparam int TD = 2, HV = 40, HF = 2, HSW = 3, HBP = 2;
    localparam int VV = 32, VF = 2, VSW = 2, VBP = 2, CELL = 4, XO = 4;
    localparam int HT = HV + HF + HSW + HBP;
    localparam int VT = VV + VF + VSW + VBP;
    localparam int FRAME = HT * VT * TD;
    localparam logic [13:0] RST_VAL = 14'h0003;
    localparam logic [13:0] BLACK   = {12'h000, 2'b11};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] reds [63:0];
    logic [3:0] greens [63:0];
    logic [3:0] blues [63:0];
    logic [3:0] r1, g1, b1, r0, g0, b0;
    logic hs1, vs1, hs0, vs0, fs1, fs0;
    logic [13:0] dut1, dut0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grid_vga_renderer #(.TICK_DIV(TD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBP),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBP), .CELL(CELL), .X_OFFSET(XO),
        .GRID_LINES(1'b1)) dut_lines (
        .CLK100MHZ(clk), .reset(reset), .reds(reds), .greens(greens), .blues(blues),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1), .o_frame_start(fs1));

    grid_vga_renderer #(.TICK_DIV(TD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBP),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBP), .CELL(CELL), .X_OFFSET(XO),
        .GRID_LINES(1'b0)) dut_plain (
        .CLK100MHZ(clk), .reset(reset), .reds(reds), .greens(greens), .blues(blues),
        .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0), .o_frame_start(fs0));

    assign dut1 = {r1, g1, b1, hs1, vs1};
    assign dut0 = {r0, g0, b0, hs0, vs0};

    // Reference model: position derived from clocks elapsed since reset release.
    logic [3:0] m_r [64];
    logic [3:0] m_g [64];
    logic [3:0] m_b [64];
    int k, cur_h, cur_v, snaps = 0;
    logic [13:0] exp1, exp0;
    logic exp_fs;

    function automatic logic [13:0] ref_pixel(int h, int v, bit lines);
        logic [11:0] c;
        logic hs, vs;
        int idx;
        c  = 12'h000;
        hs = !(h >= HV + HF && h < HV + HF + HSW);
        vs = !(v >= VV + VF && v < VV + VF + VSW);
        if (h < HV && v < VV && h >= XO && h < XO + 8 * CELL) begin
            if (lines && ((h - XO) % CELL == 0 || v % CELL == 0)) begin
                c = 12'h444;
            end else begin
                idx = (v / CELL) * 8 + (h - XO) / CELL;
                c = {m_r[idx], m_g[idx], m_b[idx]};
            end
        end
        return {c, hs, vs};
    endfunction

    always @(posedge clk or posedge reset) begin
        int p, pn;
        #1;
        if (reset) begin
            k = 0;
            for (int i = 0; i < 64; i++) begin
                m_r[i] = 4'h0; m_g[i] = 4'h0; m_b[i] = 4'h0;
            end
            exp1 = RST_VAL; exp0 = RST_VAL; exp_fs = 1'b0;
            cur_h = -1; cur_v = -1;
        end else begin
            k++;
            if (k % TD == 0) begin
                p = k / TD - 1;
                cur_h = p % HT;
                cur_v = (p / HT) % VT;
                exp1 = ref_pixel(cur_h, cur_v, 1'b1);
                exp0 = ref_pixel(cur_h, cur_v, 1'b0);
                if (cur_h == 0 && cur_v == VV) begin
                    for (int i = 0; i < 64; i++) begin
                        m_r[i] = reds[i]; m_g[i] = greens[i]; m_b[i] = blues[i];
                    end
                    snaps++;
                end
            end
            pn = (k + 1) / TD - 1;
            exp_fs = ((k + 1) % TD == 0) && (pn % HT == 0) && ((pn / HT) % VT == VV);
        end
    end

    task automatic wait_pixel(input int h, input int v);
        int n = 0;
        while (cur_h == h && cur_v == v && n < 2 * FRAME) begin @(negedge clk); n++; end
        while (!(cur_h == h && cur_v == v) && n < 2 * FRAME) begin @(negedge clk); n++; end
        checks++;
        if (n >= 2 * FRAME) begin
            errors++;
            $display("FAIL wait_pixel(%0d,%0d): got timeout after %0d clocks, required pixel reached", h, v, n);
        end
    endtask

    task automatic wait_snapshot();
        int n = 0;
        int s = snaps;
        while (snaps == s && n < 2 * FRAME) begin @(negedge clk); n++; end
        checks++;
        if (n >= 2 * FRAME) begin
            errors++;
            $display("FAIL wait_snapshot: got timeout after %0d clocks, required a snapshot", n);
        end
    endtask

    task automatic fill_grid(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        for (int i = 0; i < 64; i++) begin
            reds[i] = r; greens[i] = g; blues[i] = b;
        end
    endtask

    task automatic test_reset();
        int lat;
        repeat (3) @(negedge clk);
        checks++;
        if ({dut1, dut0, fs1, fs0} !== {RST_VAL, RST_VAL, 2'b00}) begin
            errors++;
            $display("FAIL reset_hold: got %h %h fs=%b%b, required %h %h fs=00", dut1, dut0, fs1, fs0, RST_VAL, RST_VAL);
        end
        reset = 1'b0;
        lat = 0;
        while (hs1 !== 1'b0 && lat < 2 * HT * TD) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != TD * (HV + HF + 1)) begin
            errors++;
            $display("FAIL first_hsync: got %0d clocks, required %0d", lat, TD * (HV + HF + 1));
        end
        fill_grid(4'hA, 4'h5, 4'hC);
        wait_snapshot();
        wait_pixel(20, 15);
        checks++;
        if (dut0 !== {12'hA5C, 2'b11}) begin
            errors++;
            $display("FAIL pre_reset_pixel: got %h, required %h", dut0, {12'hA5C, 2'b11});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({dut1, dut0, fs1, fs0} !== {RST_VAL, RST_VAL, 2'b00}) begin
            errors++;
            $display("FAIL reset_async: got %h %h fs=%b%b, required %h %h fs=00", dut1, dut0, fs1, fs0, RST_VAL, RST_VAL);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lat = 0;
        while (hs1 !== 1'b0 && lat < 2 * HT * TD) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != TD * (HV + HF + 1)) begin
            errors++;
            $display("FAIL restart_hsync: got %0d clocks, required %0d", lat, TD * (HV + HF + 1));
        end
        wait_pixel(XO + 1, 1);
        checks++;
        if (dut0 !== BLACK) begin
            errors++;
            $display("FAIL post_reset_black: got %h, required %h", dut0, BLACK);
        end
    endtask

    task automatic test_sync_timing();
        int n, per, hsl, vsl;
        n = 0;
        @(negedge clk);
        while (fs1 !== 1'b1 && n < 2 * FRAME) begin @(negedge clk); n++; end
        repeat (2) begin
            per = 0; hsl = 0; vsl = 0;
            do begin
                @(negedge clk);
                per++;
                if (hs1 === 1'b0) hsl++;
                if (vs1 === 1'b0) vsl++;
                checks++;
                if ({dut1, dut0, fs1, fs0} !== {exp1, exp0, exp_fs, exp_fs}) begin
                    errors++;
                    $display("FAIL sync_stream @%0t: got %h %h fs=%b%b, required %h %h fs=%b",
                             $time, dut1, dut0, fs1, fs0, exp1, exp0, exp_fs);
                end
            end while (fs1 !== 1'b1 && per < 2 * FRAME);
            checks++;
            if (per != FRAME) begin
                errors++;
                $display("FAIL frame_period: got %0d clocks, required %0d", per, FRAME);
            end
            checks++;
            if (hsl != HSW * TD * VT) begin
                errors++;
                $display("FAIL hs_low_clocks: got %0d, required %0d", hsl, HSW * TD * VT);
            end
            checks++;
            if (vsl != VSW * HT * TD) begin
                errors++;
                $display("FAIL vs_low_clocks: got %0d, required %0d", vsl, VSW * HT * TD);
            end
        end
    endtask

    task automatic test_random_frames();
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            reds[i] = 4'($urandom); greens[i] = 4'($urandom); blues[i] = 4'($urandom);
        end
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if ({dut1, dut0, fs1, fs0} !== {exp1, exp0, exp_fs, exp_fs}) begin
                errors++;
                $display("FAIL random_stream @%0t: got %h %h fs=%b%b, required %h %h fs=%b",
                         $time, dut1, dut0, fs1, fs0, exp1, exp0, exp_fs);
            end
            if ($urandom_range(0, 99) == 0) begin
                int idx = $urandom_range(0, 63);
                reds[idx] = 4'($urandom); greens[idx] = 4'($urandom); blues[idx] = 4'($urandom);
            end
        end
    endtask

    task automatic test_single_cell();
        @(negedge clk);
        fill_grid(4'h0, 4'h0, 4'h0);
        reds[9] = 4'hF;
        wait_snapshot();
        wait_pixel(8, 3);
        checks++; if (dut0 !== BLACK) begin errors++; $display("FAIL cell9_above: got %h, required %h", dut0, BLACK); end
        wait_pixel(7, 4);
        checks++; if (dut0 !== BLACK) begin errors++; $display("FAIL cell9_left: got %h, required %h", dut0, BLACK); end
        wait_pixel(8, 4);
        checks++; if (dut0 !== {12'hF00, 2'b11}) begin errors++; $display("FAIL cell9_corner: got %h, required %h", dut0, {12'hF00, 2'b11}); end
        checks++; if (dut1 !== {12'h444, 2'b11}) begin errors++; $display("FAIL cell9_line: got %h, required %h", dut1, {12'h444, 2'b11}); end
        wait_pixel(12, 4);
        checks++; if (dut0 !== BLACK) begin errors++; $display("FAIL cell9_right: got %h, required %h", dut0, BLACK); end
        wait_pixel(9, 5);
        checks++; if (dut1 !== {12'hF00, 2'b11}) begin errors++; $display("FAIL cell9_interior: got %h, required %h", dut1, {12'hF00, 2'b11}); end
        wait_pixel(11, 7);
        checks++; if (dut0 !== {12'hF00, 2'b11}) begin errors++; $display("FAIL cell9_far: got %h, required %h", dut0, {12'hF00, 2'b11}); end
        wait_pixel(8, 8);
        checks++; if (dut0 !== BLACK) begin errors++; $display("FAIL cell9_below: got %h, required %h", dut0, BLACK); end
    endtask

    task automatic test_midframe_update();
        @(negedge clk);
        fill_grid(4'h0, 4'h0, 4'h0);
        wait_snapshot();
        wait_pixel(XO + 2, 2);
        blues[0] = 4'hF;
        wait_pixel(XO + 1, 3);
        checks++; if (dut0 !== BLACK) begin errors++; $display("FAIL no_tear: got %h, required %h", dut0, BLACK); end
        wait_pixel(XO + 1, 3);
        checks++; if (dut0 !== {12'h00F, 2'b11}) begin errors++; $display("FAIL next_frame_plain: got %h, required %h", dut0, {12'h00F, 2'b11}); end
        checks++; if (dut1 !== {12'h00F, 2'b11}) begin errors++; $display("FAIL next_frame_lines: got %h, required %h", dut1, {12'h00F, 2'b11}); end
    endtask

    task automatic test_grid_lines();
        @(negedge clk);
        fill_grid(4'h0, 4'h0, 4'h0);
        wait_snapshot();
        wait_pixel(XO - 1, 0);
        checks++; if (dut1 !== BLACK) begin errors++; $display("FAIL left_of_grid: got %h, required %h", dut1, BLACK); end
        wait_pixel(XO + 2, 0);
        checks++; if (dut1 !== {12'h444, 2'b11}) begin errors++; $display("FAIL top_line: got %h, required %h", dut1, {12'h444, 2'b11}); end
        wait_pixel(XO + 8 * CELL, 0);
        checks++; if (dut1 !== BLACK) begin errors++; $display("FAIL right_of_grid: got %h, required %h", dut1, BLACK); end
        wait_pixel(XO, 5);
        checks++; if (dut1 !== {12'h444, 2'b11}) begin errors++; $display("FAIL first_column_line: got %h, required %h", dut1, {12'h444, 2'b11}); end
        checks++; if (dut0 !== BLACK) begin errors++; $display("FAIL no_lines_column: got %h, required %h", dut0, BLACK); end
        wait_pixel(XO + 2, 5);
        checks++; if (dut1 !== BLACK) begin errors++; $display("FAIL cell_interior_zero: got %h, required %h", dut1, BLACK); end
        wait_pixel(XO + CELL, 5);
        checks++; if (dut1 !== {12'h444, 2'b11}) begin errors++; $display("FAIL second_column_line: got %h, required %h", dut1, {12'h444, 2'b11}); end
        wait_pixel(XO + 7 * CELL, 9);
        checks++; if (dut1 !== {12'h444, 2'b11}) begin errors++; $display("FAIL last_column_line: got %h, required %h", dut1, {12'h444, 2'b11}); end
        wait_pixel(XO + 2, 7 * CELL);
        checks++; if (dut1 !== {12'h444, 2'b11}) begin errors++; $display("FAIL last_row_line: got %h, required %h", dut1, {12'h444, 2'b11}); end
    endtask

    task automatic test_all_white();
        @(negedge clk);
        fill_grid(4'hF, 4'hF, 4'hF);
        wait_snapshot();
        wait_pixel(XO, 1);
        checks++; if (dut1 !== {12'h444, 2'b11}) begin errors++; $display("FAIL white_line: got %h, required %h", dut1, {12'h444, 2'b11}); end
        checks++; if (dut0 !== {12'hFFF, 2'b11}) begin errors++; $display("FAIL white_edge_plain: got %h, required %h", dut0, {12'hFFF, 2'b11}); end
        wait_pixel(XO + 1, 1);
        checks++; if (dut1 !== {12'hFFF, 2'b11}) begin errors++; $display("FAIL white_interior: got %h, required %h", dut1, {12'hFFF, 2'b11}); end
        wait_pixel(XO - 1, 5);
        checks++; if (dut0 !== BLACK) begin errors++; $display("FAIL white_left: got %h, required %h", dut0, BLACK); end
        wait_pixel(XO + 8 * CELL, 5);
        checks++; if (dut0 !== BLACK) begin errors++; $display("FAIL white_right: got %h, required %h", dut0, BLACK); end
        wait_pixel(HV + 1, 5);
        checks++; if (dut1 !== BLACK) begin errors++; $display("FAIL white_hblank: got %h, required %h", dut1, BLACK); end
        wait_pixel(10, VV + 1);
        checks++; if (dut1 !== BLACK) begin errors++; $display("FAIL white_vblank: got %h, required %h", dut1, BLACK); end
    endtask

    initial begin
        fill_grid(4'h0, 4'h0, 4'h0);
        test_reset();
        test_sync_timing();
        test_random_frames();
        test_single_cell();
        test_midframe_update();
        test_grid_lines();
        test_all_white();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
